// File: rtl/kimlik_kayit_pkg.sv
// Shared definitions for the ID table writer: default sizes, operation codes,
// result codes and FSM state encodings.
package kimlik_kayit_pkg;

    localparam int BIT_VARS      = 6;
    localparam int DERINLIK_VARS = 10;

    localparam logic EKLE = 1'b0;
    localparam logic SIL  = 1'b1;

    localparam logic [1:0] HATA_YOK     = 2'b00;
    localparam logic [1:0] HATA_VAR_YOK = 2'b01;
    localparam logic [1:0] HATA_DOLU    = 2'b10;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        TARA  = 2'd1,
        ISLE  = 2'd2
    } durum_t;

endpackage

// File: rtl/kimlik_kayit_tablo.sv
// One ID table: DERINLIK entries with valid bits, a single set/clear write
// port, a combinational scan read and a bounds-checked export read.
module kimlik_kayit_tablo
    import kimlik_kayit_pkg::*;
#(
    parameter int BIT      = BIT_VARS,
    parameter int DERINLIK = DERINLIK_VARS,
    parameter int ADRES    = $clog2(DERINLIK)
) (
    input  logic             saat,
    input  logic             reset,
    input  logic             yaz,
    input  logic [ADRES-1:0] yaz_adres,
    input  logic [BIT-1:0]   yaz_veri,
    input  logic             sil,
    input  logic [ADRES-1:0] sil_adres,
    input  logic [ADRES-1:0] tara_adres,
    output logic [BIT-1:0]   tara_veri,
    output logic             tara_gecerli,
    input  logic [ADRES-1:0] oku_adres,
    output logic [BIT-1:0]   oku_veri,
    output logic             oku_gecerli
);

    localparam logic [ADRES:0] SINIR = (ADRES+1)'(DERINLIK);

    logic [BIT-1:0]      veri [DERINLIK];
    logic [DERINLIK-1:0] gecerli;

    // Entry storage: set writes data and valid, clear drops only the valid bit.
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DERINLIK; i++) begin
                veri[i] <= '0;
            end
            gecerli <= '0;
        end else begin
            if (yaz) begin
                veri[yaz_adres]    <= yaz_veri;
                gecerli[yaz_adres] <= 1'b1;
            end
            if (sil) begin
                gecerli[sil_adres] <= 1'b0;
            end
        end
    end

    // Scan index is always in range; the FSM never drives it past the last entry.
    assign tara_veri    = veri[tara_adres];
    assign tara_gecerli = gecerli[tara_adres];

    // Export read returns zeros for indices past the table end.
    always_comb begin
        oku_veri    = '0;
        oku_gecerli = 1'b0;
        if ({1'b0, oku_adres} < SINIR) begin
            oku_veri    = veri[oku_adres];
            oku_gecerli = gecerli[oku_adres];
        end
    end

endmodule

// File: rtl/kimlik_kayit.sv
// Run-time writer for the domestic/foreign ID tables: scans the selected table
// for a duplicate and the lowest free slot, then commits an add or delete.
//
// state | meaning
// BOSTA | idle, accepts basla; also the cycle in which bitti is high
// TARA  | scanning one entry per clock, idx 0..DERINLIK-1
// ISLE  | commit write/clear, latch result, raise bitti
module kimlik_kayit
    import kimlik_kayit_pkg::*;
#(
    parameter int BIT      = BIT_VARS,
    parameter int DERINLIK = DERINLIK_VARS,
    parameter int ADRES    = $clog2(DERINLIK)
) (
    input  logic             saat,
    input  logic             reset,
    input  logic             basla,
    input  logic             islem,
    input  logic [BIT-1:0]   kimlik_no,
    input  logic             uyruk,
    output logic             mesgul,
    output logic             bitti,
    output logic             basarili,
    output logic [1:0]       hata_kod,
    output logic [ADRES:0]   yerli_sayi,
    output logic [ADRES:0]   yabanci_sayi,
    input  logic             oku_uyruk,
    input  logic [ADRES-1:0] oku_adres,
    output logic [BIT-1:0]   oku_veri,
    output logic             oku_gecerli
);

    localparam logic [ADRES-1:0] SON_IDX = ADRES'(DERINLIK - 1);

    durum_t durum, sonraki;

    logic [ADRES-1:0] idx, esles_idx, bos_idx;
    logic             esles, bos_var;
    logic             islem_r, uyruk_r;
    logic [BIT-1:0]   kimlik_r;

    logic             ekle_ok, sil_ok;
    logic             yaz_yerli, yaz_yabanci, sil_yerli, sil_yabanci;

    logic [BIT-1:0]   tv_yerli, tv_yabanci, ov_yerli, ov_yabanci;
    logic             tg_yerli, tg_yabanci, og_yerli, og_yabanci;
    logic [BIT-1:0]   tara_veri;
    logic             tara_gecerli;

    kimlik_kayit_tablo #(.BIT(BIT), .DERINLIK(DERINLIK), .ADRES(ADRES)) u_yerli (
        .saat(saat), .reset(reset),
        .yaz(yaz_yerli), .yaz_adres(bos_idx), .yaz_veri(kimlik_r),
        .sil(sil_yerli), .sil_adres(esles_idx),
        .tara_adres(idx), .tara_veri(tv_yerli), .tara_gecerli(tg_yerli),
        .oku_adres(oku_adres), .oku_veri(ov_yerli), .oku_gecerli(og_yerli)
    );

    kimlik_kayit_tablo #(.BIT(BIT), .DERINLIK(DERINLIK), .ADRES(ADRES)) u_yabanci (
        .saat(saat), .reset(reset),
        .yaz(yaz_yabanci), .yaz_adres(bos_idx), .yaz_veri(kimlik_r),
        .sil(sil_yabanci), .sil_adres(esles_idx),
        .tara_adres(idx), .tara_veri(tv_yabanci), .tara_gecerli(tg_yabanci),
        .oku_adres(oku_adres), .oku_veri(ov_yabanci), .oku_gecerli(og_yabanci)
    );

    assign tara_veri    = uyruk_r ? tv_yabanci : tv_yerli;
    assign tara_gecerli = uyruk_r ? tg_yabanci : tg_yerli;
    assign oku_veri     = oku_uyruk ? ov_yabanci : ov_yerli;
    assign oku_gecerli  = oku_uyruk ? og_yabanci : og_yerli;

    // State register.
    always_ff @(posedge saat or posedge reset) begin
        if (reset) durum <= BOSTA;
        else       durum <= sonraki;
    end

    // Next-state logic.
    always_comb begin
        sonraki = durum;
        case (durum)
            BOSTA:   if (basla) sonraki = TARA;
            TARA:    if (idx == SON_IDX) sonraki = ISLE;
            ISLE:    sonraki = BOSTA;
            default: sonraki = BOSTA;
        endcase
    end

    // Commit decisions and table write strobes, only in ISLE.
    always_comb begin
        ekle_ok     = 1'b0;
        sil_ok      = 1'b0;
        yaz_yerli   = 1'b0;
        yaz_yabanci = 1'b0;
        sil_yerli   = 1'b0;
        sil_yabanci = 1'b0;
        if (durum == ISLE) begin
            ekle_ok     = (islem_r == EKLE) && !esles && bos_var;
            sil_ok      = (islem_r == SIL) && esles;
            yaz_yerli   = ekle_ok && !uyruk_r;
            yaz_yabanci = ekle_ok && uyruk_r;
            sil_yerli   = sil_ok && !uyruk_r;
            sil_yabanci = sil_ok && uyruk_r;
        end
    end

    // Request latch, scan trackers, counters and result registers.
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            mesgul       <= 1'b0;
            bitti        <= 1'b0;
            basarili     <= 1'b0;
            hata_kod     <= HATA_YOK;
            yerli_sayi   <= '0;
            yabanci_sayi <= '0;
            idx          <= '0;
            esles        <= 1'b0;
            esles_idx    <= '0;
            bos_var      <= 1'b0;
            bos_idx      <= '0;
            islem_r      <= EKLE;
            uyruk_r      <= 1'b0;
            kimlik_r     <= '0;
        end else begin
            case (durum)
                BOSTA: begin
                    // The bitti cycle lives here, so a request right after completion is taken.
                    bitti  <= 1'b0;
                    mesgul <= basla;
                    if (basla) begin
                        islem_r   <= islem;
                        uyruk_r   <= uyruk;
                        kimlik_r  <= kimlik_no;
                        idx       <= '0;
                        esles     <= 1'b0;
                        esles_idx <= '0;
                        bos_var   <= 1'b0;
                        bos_idx   <= '0;
                    end
                end
                TARA: begin
                    if (tara_gecerli && (tara_veri == kimlik_r)) begin
                        esles     <= 1'b1;
                        esles_idx <= idx;
                    end
                    if (!tara_gecerli && !bos_var) begin
                        bos_var <= 1'b1;
                        bos_idx <= idx;
                    end
                    if (idx != SON_IDX) idx <= idx + ADRES'(1);
                end
                ISLE: begin
                    bitti    <= 1'b1;
                    basarili <= ekle_ok || sil_ok;
                    if (islem_r == EKLE) begin
                        if (esles)         hata_kod <= HATA_VAR_YOK;
                        else if (!bos_var) hata_kod <= HATA_DOLU;
                        else               hata_kod <= HATA_YOK;
                    end else begin
                        hata_kod <= esles ? HATA_YOK : HATA_VAR_YOK;
                    end
                    if (ekle_ok) begin
                        if (uyruk_r) yabanci_sayi <= yabanci_sayi + (ADRES+1)'(1);
                        else         yerli_sayi   <= yerli_sayi + (ADRES+1)'(1);
                    end
                    if (sil_ok) begin
                        if (uyruk_r) yabanci_sayi <= yabanci_sayi - (ADRES+1)'(1);
                        else         yerli_sayi   <= yerli_sayi - (ADRES+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kimlik_kayit.sv
// Directed bench for kimlik_kayit: add/delete, duplicate, full, lowest-free
// reuse, busy-time strobes, mid-scan reset and the export read port.
module tb_kimlik_kayit;

    logic       saat = 1'b0;
    logic       reset;
    logic       basla = 1'b0;
    logic       islem = 1'b0;
    logic [5:0] kimlik_no = '0;
    logic       uyruk = 1'b0;
    logic       mesgul, bitti, basarili;
    logic [1:0] hata_kod;
    logic [4:0] yerli_sayi, yabanci_sayi;
    logic       oku_uyruk = 1'b0;
    logic [3:0] oku_adres = '0;
    logic [5:0] oku_veri;
    logic       oku_gecerli;

    int checks = 0;
    int errors = 0;
    int gecikme;
    int sayac;

    kimlik_kayit dut (
        .saat(saat), .reset(reset), .basla(basla), .islem(islem),
        .kimlik_no(kimlik_no), .uyruk(uyruk), .mesgul(mesgul), .bitti(bitti),
        .basarili(basarili), .hata_kod(hata_kod), .yerli_sayi(yerli_sayi),
        .yabanci_sayi(yabanci_sayi), .oku_uyruk(oku_uyruk), .oku_adres(oku_adres),
        .oku_veri(oku_veri), .oku_gecerli(oku_gecerli)
    );

    always #5 saat = ~saat;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        checks++;
        if (gozlenen !== beklenen) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", etiket, gozlenen, beklenen);
        end
    endtask

    // Issue one request and return with the bench sitting 1 time unit after the bitti edge.
    task automatic istek(input logic isl, input logic [5:0] id, input logic uyr, output int gec);
        @(negedge saat);
        basla = 1'b1; islem = isl; kimlik_no = id; uyruk = uyr;
        @(posedge saat); #1;
        basla = 1'b0;
        gec = 0;
        while (!bitti && gec < 40) begin
            @(posedge saat); #1;
            gec++;
        end
    endtask

    task automatic oku(input logic uyr, input logic [3:0] adr, output logic [5:0] v, output logic g);
        oku_uyruk = uyr; oku_adres = adr;
        #1;
        v = oku_veri; g = oku_gecerli;
    endtask

    logic [5:0] v;
    logic       g;

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge saat);
        #1;
        kontrol("rst_mesgul", mesgul, 0);
        kontrol("rst_bitti", bitti, 0);
        kontrol("rst_sayi", yerli_sayi, 0);
        oku(0, 0, v, g);
        kontrol("rst_gecerli", g, 0);
        @(negedge saat); reset = 1'b0;

        // 1: first add, latency, visibility right after the commit edge
        istek(0, 6'd5, 0, gecikme);
        kontrol("t1_gecikme", gecikme, 11);
        kontrol("t1_basarili", basarili, 1);
        kontrol("t1_hata", hata_kod, 0);
        kontrol("t1_mesgul", mesgul, 1);
        oku(0, 0, v, g);
        kontrol("t1_veri", v, 5);
        kontrol("t1_gecerli", g, 1);
        kontrol("t1_sayi", yerli_sayi, 1);
        @(posedge saat); #1;
        kontrol("t1_bitti_dusuk", bitti, 0);
        kontrol("t1_mesgul_dusuk", mesgul, 0);

        // 2: duplicate in yerli, same id accepted in yabanci
        istek(0, 6'd5, 0, gecikme);
        kontrol("t2_hata", hata_kod, 1);
        kontrol("t2_basarili", basarili, 0);
        kontrol("t2_sayi", yerli_sayi, 1);
        istek(0, 6'd5, 1, gecikme);
        kontrol("t2_yab_hata", hata_kod, 0);
        kontrol("t2_yab_sayi", yabanci_sayi, 1);
        kontrol("t2_yerli_sabit", yerli_sayi, 1);
        oku(1, 0, v, g);
        kontrol("t2_yab_veri", v, 5);
        oku(0, 1, v, g);
        kontrol("t2_yerli_slot1", g, 0);

        // 3: fill yerli with ids 10..18 in slots 1..9, then full and precedence
        for (int i = 0; i < 9; i++) begin
            istek(0, 6'(10 + i), 0, gecikme);
            kontrol("t3_dolum", hata_kod, 0);
        end
        kontrol("t3_sayi", yerli_sayi, 10);
        istek(0, 6'd63, 0, gecikme);
        kontrol("t3_dolu", hata_kod, 2);
        kontrol("t3_dolu_bas", basarili, 0);
        kontrol("t3_sayi_sabit", yerli_sayi, 10);
        istek(0, 6'd5, 0, gecikme);
        kontrol("t3_oncelik", hata_kod, 1);

        // 6 (part): out-of-range read index
        oku(0, 4'd12, v, g);
        kontrol("t6_veri12", v, 0);
        kontrol("t6_gecerli12", g, 0);

        // 4: delete slot 3 (id 12), refill lowest free slot, delete absent id
        istek(1, 6'd12, 0, gecikme);
        kontrol("t4_sil_hata", hata_kod, 0);
        kontrol("t4_sil_bas", basarili, 1);
        kontrol("t4_sil_sayi", yerli_sayi, 9);
        oku(0, 3, v, g);
        kontrol("t4_slot3_bos", g, 0);
        istek(0, 6'd40, 0, gecikme);
        kontrol("t4_ekle_hata", hata_kod, 0);
        oku(0, 3, v, g);
        kontrol("t4_slot3_veri", v, 40);
        kontrol("t4_slot3_gecerli", g, 1);
        kontrol("t4_sayi", yerli_sayi, 10);
        istek(1, 6'd50, 0, gecikme);
        kontrol("t4_yok", hata_kod, 1);
        kontrol("t4_yok_bas", basarili, 0);
        istek(1, 6'd0, 0, gecikme);
        kontrol("t4_sifir_yok", hata_kod, 1);

        // 5a: basla while busy is ignored
        @(negedge saat);
        basla = 1'b1; islem = 1'b0; kimlik_no = 6'd7; uyruk = 1'b1;
        @(posedge saat); #1; basla = 1'b0;
        repeat (3) @(posedge saat);
        @(negedge saat);
        basla = 1'b1; kimlik_no = 6'd9;
        @(posedge saat); #1; basla = 1'b0;
        sayac = 0;
        repeat (25) begin
            @(posedge saat); #1;
            if (bitti) sayac++;
        end
        kontrol("t5_tek_bitti", sayac, 1);
        kontrol("t5_yab_sayi", yabanci_sayi, 2);
        oku(1, 1, v, g);
        kontrol("t5_yab_veri", v, 7);
        oku(1, 2, v, g);
        kontrol("t5_yab_slot2", g, 0);

        // 5b: reset during TARA aborts and clears
        @(negedge saat);
        basla = 1'b1; islem = 1'b0; kimlik_no = 6'd20; uyruk = 1'b0;
        @(posedge saat); #1; basla = 1'b0;
        repeat (3) @(posedge saat);
        #1 reset = 1'b1;
        #2;
        kontrol("t5_rst_mesgul", mesgul, 0);
        kontrol("t5_rst_sayi", yerli_sayi, 0);
        kontrol("t5_rst_yab", yabanci_sayi, 0);
        @(negedge saat); reset = 1'b0;
        sayac = 0;
        repeat (15) begin
            @(posedge saat); #1;
            if (bitti) sayac++;
        end
        kontrol("t5_rst_bitti", sayac, 0);
        oku(0, 0, v, g);
        kontrol("t5_rst_gecerli", g, 0);
        oku(0, 4, v, g);
        kontrol("t5_rst_veri", v, 0);

        // back-to-back: next request sampled at the edge that drops bitti
        istek(0, 6'd0, 0, gecikme);
        kontrol("bb1_hata", hata_kod, 0);
        istek(0, 6'd1, 0, gecikme);
        kontrol("bb2_gecikme", gecikme, 11);
        kontrol("bb2_sayi", yerli_sayi, 2);
        oku(0, 0, v, g);
        kontrol("bb_id0_gecerli", g, 1);
        oku(0, 1, v, g);
        kontrol("bb_id1_veri", v, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
